// File: rtl/io_bus_ctrl.sv
// IO-window bus controller: decodes CPU load/store requests into one peripheral
// chip select, drives the shared write bus and returns read data with ready/err.
module io_bus_ctrl #(
   parameter logic [21:0] IO_BASE    = 22'h3FFFFF,
   parameter logic [9:0]  LED_OFS    = 10'h060,
   parameter logic [9:0]  SW_OFS     = 10'h070,
   parameter logic [9:0]  SEG_OFS    = 10'h000,
   parameter logic [9:0]  TMR_OFS    = 10'h020,
   parameter int          ACC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        isReset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_err,
   output logic [15:0] io_dR,
   input  logic [15:0] io_dW,
   output logic        io_isW,
   output logic        io_isCS_led,
   output logic        io_isCS_sw,
   output logic        io_isCS_seg,
   output logic        io_isCS_tmr
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [3:0] CNT_INIT  = 4'(ACC_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cs_q, cs_d;
   logic        is_w_q, is_w_d;
   logic [15:0] d_r_q, d_r_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        in_window;
   logic        req;
   logic [3:0]  dev_sel;
   logic        unused_bits;

   assign in_window   = (cpu_addr[31:10] == IO_BASE);
   assign req         = cpu_rd | cpu_wr;
   assign unused_bits = ^{cpu_wdata[31:16], cpu_addr[3:1]};

   // Priority encode so overlapping offsets can never raise two chip selects.
   always_comb begin
      dev_sel = 4'b0000;
      if (cpu_addr[9:4] == LED_OFS[9:4])      dev_sel = 4'b1000;
      else if (cpu_addr[9:4] == SW_OFS[9:4])  dev_sel = 4'b0100;
      else if (cpu_addr[9:4] == SEG_OFS[9:4]) dev_sel = 4'b0010;
      else if (cpu_addr[9:4] == TMR_OFS[9:4]) dev_sel = 4'b0001;
   end

   always_comb begin
      state_d = state_q;
      cs_d    = cs_q;
      is_w_d  = is_w_q;
      d_r_d   = d_r_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_window && req) begin
               if ((cpu_rd && cpu_wr) || cpu_addr[0] || (dev_sel == 4'b0000)) begin
                  state_d = ST_DONE;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else begin
                  cs_d    = dev_sel;
                  is_w_d  = cpu_wr;
                  if (cpu_wr) d_r_d = cpu_wdata[15:0];
                  cnt_d   = CNT_INIT;
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!is_w_q) rdata_d = {16'h0, io_dW};
               cs_d    = 4'b0000;
               is_w_d  = 1'b0;
               ready_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cs_d    = 4'b0000;
            is_w_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (isReset) begin
         state_q <= ST_IDLE;
         cs_q    <= 4'b0000;
         is_w_q  <= 1'b0;
         d_r_q   <= 16'h0;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         is_w_q  <= is_w_d;
         d_r_q   <= d_r_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cpu_rdata   = rdata_q;
   assign cpu_ready   = ready_q;
   assign cpu_err     = err_q;
   assign io_dR       = d_r_q;
   assign io_isW      = is_w_q;
   assign io_isCS_led = cs_q[3];
   assign io_isCS_sw  = cs_q[2];
   assign io_isCS_seg = cs_q[1];
   assign io_isCS_tmr = cs_q[0];

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: three instances with access lengths 1, 3 and 4
// share clock, reset, address and data; each has its own rd/wr request lines.
module tb_io_bus_ctrl;

   localparam int ACC [3] = '{1, 3, 4};

   logic        clk = 1'b0;
   logic        isReset = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [15:0] dw = 16'h0;
   logic [2:0]  rd = 3'b000;
   logic [2:0]  wr = 3'b000;

   logic [31:0] rdata [3];
   logic        ready [3];
   logic        err [3];
   logic        isw [3];
   logic [15:0] dr [3];
   logic        cs_led [3];
   logic        cs_sw [3];
   logic        cs_seg [3];
   logic        cs_tmr [3];

   logic [15:0] led_model [3] = '{16'h0, 16'h0, 16'h0};
   int          led_cnt [3] = '{0, 0, 0};

   int total_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   io_bus_ctrl #(.ACC_CYCLES(1)) u_dut0 (
      .clk(clk), .isReset(isReset), .cpu_addr(addr), .cpu_wdata(wdata),
      .cpu_rd(rd[0]), .cpu_wr(wr[0]), .cpu_rdata(rdata[0]), .cpu_ready(ready[0]),
      .cpu_err(err[0]), .io_dR(dr[0]), .io_dW(dw), .io_isW(isw[0]),
      .io_isCS_led(cs_led[0]), .io_isCS_sw(cs_sw[0]), .io_isCS_seg(cs_seg[0]),
      .io_isCS_tmr(cs_tmr[0]));

   io_bus_ctrl #(.ACC_CYCLES(3)) u_dut1 (
      .clk(clk), .isReset(isReset), .cpu_addr(addr), .cpu_wdata(wdata),
      .cpu_rd(rd[1]), .cpu_wr(wr[1]), .cpu_rdata(rdata[1]), .cpu_ready(ready[1]),
      .cpu_err(err[1]), .io_dR(dr[1]), .io_dW(dw), .io_isW(isw[1]),
      .io_isCS_led(cs_led[1]), .io_isCS_sw(cs_sw[1]), .io_isCS_seg(cs_seg[1]),
      .io_isCS_tmr(cs_tmr[1]));

   io_bus_ctrl #(.ACC_CYCLES(4)) u_dut2 (
      .clk(clk), .isReset(isReset), .cpu_addr(addr), .cpu_wdata(wdata),
      .cpu_rd(rd[2]), .cpu_wr(wr[2]), .cpu_rdata(rdata[2]), .cpu_ready(ready[2]),
      .cpu_err(err[2]), .io_dR(dr[2]), .io_dW(dw), .io_isW(isw[2]),
      .io_isCS_led(cs_led[2]), .io_isCS_sw(cs_sw[2]), .io_isCS_seg(cs_seg[2]),
      .io_isCS_tmr(cs_tmr[2]));

   // LED peripheral model: commits on the negedge of the last chip-select cycle,
   // so an access cut short by reset leaves the register untouched.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (cs_led[i] && isw[i]) begin
            if (led_cnt[i] + 1 == ACC[i]) led_model[i] <= dr[i];
            led_cnt[i] <= led_cnt[i] + 1;
         end else begin
            led_cnt[i] <= 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      isReset = 1'b1;
      wr = 3'b111;
      addr = 32'hFFFFFC60;
      wdata = 32'h00001111;
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({cs_led[i], cs_sw[i], cs_seg[i], cs_tmr[i]} !== 4'b0000)
               $display("[TB] FAIL reset_cs dut%0d: got %b want 0000", i, {cs_led[i], cs_sw[i], cs_seg[i], cs_tmr[i]});
            else pass_cnt++;
            total_cnt++;
            if (ready[i] !== 1'b0) $display("[TB] FAIL reset_ready dut%0d: got %b want 0", i, ready[i]);
            else pass_cnt++;
            total_cnt++;
            if (rdata[i] !== 32'h0) $display("[TB] FAIL reset_rdata dut%0d: got %h want 00000000", i, rdata[i]);
            else pass_cnt++;
         end
      end
      isReset = 1'b0;
      wr = 3'b000;
      tick();
   endtask

   task automatic test_led_write();
      addr = 32'hFFFFFC60;
      wdata = 32'h0000A5C3;
      wr[0] = 1'b1;
      tick();
      total_cnt++;
      if ({cs_led[0], cs_sw[0], cs_seg[0], cs_tmr[0]} !== 4'b1000)
         $display("[TB] FAIL led_cs: got %b want 1000", {cs_led[0], cs_sw[0], cs_seg[0], cs_tmr[0]});
      else pass_cnt++;
      total_cnt++;
      if (isw[0] !== 1'b1 || dr[0] !== 16'hA5C3)
         $display("[TB] FAIL led_bus: got isW=%b dR=%h want isW=1 dR=a5c3", isw[0], dr[0]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ready[0] !== 1'b1 || err[0] !== 1'b0 || cs_led[0] !== 1'b0 || isw[0] !== 1'b0)
         $display("[TB] FAIL led_done: got ready=%b err=%b cs=%b isW=%b want 1 0 0 0", ready[0], err[0], cs_led[0], isw[0]);
      else pass_cnt++;
      wr[0] = 1'b0;
      tick();
      total_cnt++;
      if (ready[0] !== 1'b0) $display("[TB] FAIL led_ready_pulse: got %b want 0", ready[0]);
      else pass_cnt++;
      total_cnt++;
      if (led_model[0] !== 16'hA5C3) $display("[TB] FAIL led_model: got %h want a5c3", led_model[0]);
      else pass_cnt++;
   endtask

   task automatic test_sw_read();
      int  cs_cycles = 0;
      bit  got_ready = 1'b0;
      bit  isw_bad = 1'b0;
      addr = 32'hFFFFFC70;
      dw = 16'h1234;
      rd[1] = 1'b1;
      for (int c = 0; c < 12 && !got_ready; c++) begin
         tick();
         if (cs_sw[1]) cs_cycles++;
         if (cs_sw[1] && isw[1]) isw_bad = 1'b1;
         if (ready[1]) got_ready = 1'b1;
      end
      total_cnt++;
      if (got_ready !== 1'b1) $display("[TB] FAIL sw_timeout: got ready=%b want 1 within 12 cycles", got_ready);
      else pass_cnt++;
      total_cnt++;
      if (cs_cycles != 3) $display("[TB] FAIL sw_cs_len: got %0d want 3", cs_cycles);
      else pass_cnt++;
      total_cnt++;
      if (isw_bad !== 1'b0) $display("[TB] FAIL sw_isW: got isW=1 during read want 0");
      else pass_cnt++;
      total_cnt++;
      if (rdata[1] !== 32'h00001234 || err[1] !== 1'b0)
         $display("[TB] FAIL sw_rdata: got %h err=%b want 00001234 err=0", rdata[1], err[1]);
      else pass_cnt++;
      rd[1] = 1'b0;
      tick();
   endtask

   task automatic test_faults();
      addr = 32'hFFFFFC40;
      rd[1] = 1'b1;
      tick();
      total_cnt++;
      if (ready[1] !== 1'b1 || err[1] !== 1'b1 || rdata[1] !== 32'h0 ||
          {cs_led[1], cs_sw[1], cs_seg[1], cs_tmr[1]} !== 4'b0000)
         $display("[TB] FAIL fault_nodev: got ready=%b err=%b rdata=%h cs=%b want 1 1 00000000 0000",
                  ready[1], err[1], rdata[1], {cs_led[1], cs_sw[1], cs_seg[1], cs_tmr[1]});
      else pass_cnt++;
      rd[1] = 1'b0;
      tick();
      total_cnt++;
      if (ready[1] !== 1'b0 || err[1] !== 1'b0)
         $display("[TB] FAIL fault_clear: got ready=%b err=%b want 0 0", ready[1], err[1]);
      else pass_cnt++;
      addr = 32'hFFFFFC61;
      wdata = 32'h00005555;
      wr[1] = 1'b1;
      tick();
      total_cnt++;
      if (ready[1] !== 1'b1 || err[1] !== 1'b1 || {cs_led[1], cs_sw[1], cs_seg[1], cs_tmr[1]} !== 4'b0000)
         $display("[TB] FAIL fault_odd: got ready=%b err=%b cs=%b want 1 1 0000",
                  ready[1], err[1], {cs_led[1], cs_sw[1], cs_seg[1], cs_tmr[1]});
      else pass_cnt++;
      wr[1] = 1'b0;
      tick();
      addr = 32'hFFFFFC60;
      rd[1] = 1'b1;
      wr[1] = 1'b1;
      tick();
      total_cnt++;
      if (ready[1] !== 1'b1 || err[1] !== 1'b1 || {cs_led[1], cs_sw[1], cs_seg[1], cs_tmr[1]} !== 4'b0000)
         $display("[TB] FAIL fault_rdwr: got ready=%b err=%b cs=%b want 1 1 0000",
                  ready[1], err[1], {cs_led[1], cs_sw[1], cs_seg[1], cs_tmr[1]});
      else pass_cnt++;
      rd[1] = 1'b0;
      wr[1] = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [5:0] seg_pat = 6'b0;
      logic [5:0] rdy_pat = 6'b0;
      bit         activity = 1'b0;
      addr = 32'hFFFFFC00;
      wdata = 32'h00007E01;
      wr[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         seg_pat[c] = cs_seg[0];
         rdy_pat[c] = ready[0];
         if (c == 4) addr = 32'h00001000;
      end
      total_cnt++;
      if (seg_pat !== 6'b001001) $display("[TB] FAIL b2b_cs: got %b want 001001", seg_pat);
      else pass_cnt++;
      total_cnt++;
      if (rdy_pat !== 6'b010010) $display("[TB] FAIL b2b_ready: got %b want 010010", rdy_pat);
      else pass_cnt++;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (cs_led[0] || cs_sw[0] || cs_seg[0] || cs_tmr[0] || ready[0]) activity = 1'b1;
      end
      total_cnt++;
      if (activity !== 1'b0) $display("[TB] FAIL b2b_outside: got activity=1 want 0");
      else pass_cnt++;
      total_cnt++;
      if (dr[0] !== 16'h7E01) $display("[TB] FAIL b2b_dR: got %h want 7e01", dr[0]);
      else pass_cnt++;
      wr[0] = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      bit rdy_seen = 1'b0;
      addr = 32'hFFFFFC60;
      wdata = 32'h0000BEEF;
      wr[2] = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (cs_led[2] !== 1'b1) $display("[TB] FAIL rst_mid_cs_before: got %b want 1", cs_led[2]);
      else pass_cnt++;
      isReset = 1'b1;
      tick();
      total_cnt++;
      if ({cs_led[2], cs_sw[2], cs_seg[2], cs_tmr[2]} !== 4'b0000 || ready[2] !== 1'b0)
         $display("[TB] FAIL rst_mid_cs_after: got cs=%b ready=%b want 0000 0",
                  {cs_led[2], cs_sw[2], cs_seg[2], cs_tmr[2]}, ready[2]);
      else pass_cnt++;
      isReset = 1'b0;
      wr[2] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ready[2]) rdy_seen = 1'b1;
      end
      total_cnt++;
      if (rdy_seen !== 1'b0) $display("[TB] FAIL rst_mid_ready: got ready pulse want none");
      else pass_cnt++;
      total_cnt++;
      if (led_model[2] !== 16'h0000) $display("[TB] FAIL rst_mid_led: got %h want 0000", led_model[2]);
      else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_led_write();
      test_sw_read();
      test_faults();
      test_back_to_back();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Upstream stage of the memory-mapped IO peripherals (LED, switch, 7-seg, timer).
- Takes the CPU's IO-window load/store request and decodes the address into one peripheral chip select.
- Drives the shared isW and 16-bit write bus to the peripherals, captures the selected peripheral's read bus, and returns data to the CPU with a ready/err handshake and a programmable access length.

Parameters:
- IO_BASE, 22'h3FFFFF, value of cpu_addr[31:10] that identifies the IO window
- LED_OFS, 10'h060, 16-byte device window offset for LED (matched on addr[9:4])
- SW_OFS, 10'h070, device window offset for switches
- SEG_OFS, 10'h000, device window offset for 7-segment
- TMR_OFS, 10'h020, device window offset for timer
- ACC_CYCLES, 1, cycles chip select is held per access (1..15)

Ports:
- clk  in  1  system clock; controller acts on posedge, peripherals sample on negedge
- isReset  in  1  synchronous active-high reset
- cpu_addr  in  32  byte address, valid while cpu_rd or cpu_wr is high
- cpu_wdata  in  32  store data; only [15:0] is used
- cpu_rd  in  1  load request, held until cpu_ready
- cpu_wr  in  1  store request, held until cpu_ready
- cpu_rdata  out  32  load result, zero-extended from 16 bits
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ready; access faulted
- io_dR  out  16  write data to peripherals
- io_dW  in  16  shared peripheral read bus; high-Z when no device drives it
- io_isW  out  1  1 = write, 0 = read
- io_isCS_led, io_isCS_sw, io_isCS_seg, io_isCS_tmr  out  1 each  one-hot chip selects

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on isReset, sampled at posedge.
- Reset values: state IDLE; all CS=0; io_isW=0; io_dR=0; cpu_rdata=0; cpu_ready=0; cpu_err=0; access counter=0.
- All outputs are registered. States: IDLE, ACCESS, DONE.
- IDLE, request decode (evaluated only when cpu_addr[31:10]==IO_BASE and cpu_rd|cpu_wr):
  - cpu_rd&cpu_wr both set, or cpu_addr[0]=1: go to DONE with err=1; no CS.
  - addr[9:4] matches no device offset: go to DONE with err=1 and cpu_rdata=0; no CS.
  - Otherwise: latch the direction, set io_isW=cpu_wr, set io_dR=cpu_wdata[15:0] (writes only; io_dR is unchanged on reads), assert the matching CS, load counter=ACC_CYCLES-1, go to ACCESS.
  - Address outside the IO window: ignored; stay in IDLE with no response.
- ACCESS:
  - CS, io_isW and io_dR are stable for exactly ACC_CYCLES clocks. Peripherals perform the write on an interior negedge.
  - counter!=0: decrement and stay.
  - counter==0 on a read: cpu_rdata<={16'h0,io_dW} at this edge.
  - counter==0 (read or write): drop all CS, set io_isW=0, set cpu_ready=1 with cpu_err=0, go to DONE.
- DONE:
  - cpu_ready=1 for this single cycle, with cpu_err as decided.
  - Next edge: ready/err=0, go to IDLE.
- Latency: request sampled at edge N; CS high during cycles N..N+ACC_CYCLES-1; ready high in the cycle after edge N+ACC_CYCLES.
- Request handling:
  - A request still held in IDLE after DONE starts a new access, so back-to-back accesses are legal.
  - Request changes during ACCESS are ignored, because all access parameters are latched.
- cpu_rdata holds its value until the next successful read or a faulted access.
- Reset mid-ACCESS: on that edge all CS drop, the state returns to IDLE, no ready is issued, and the write is abandoned.
- Invariants: at most one CS is high in any cycle; no CS is high in IDLE or DONE.

Test Plan:
- Reset: assert isReset 2 cycles with cpu_wr=1 to 0xFFFFFC60 -> all CS=0, ready=0, rdata=0 throughout.
- LED write: cpu_wr=1, addr=0xFFFFFC60, wdata=0x0000A5C3, ACC_CYCLES=1 -> io_isCS_led=1, io_isW=1, io_dR=0xA5C3 for 1 cycle; ready pulse 1 cycle later with err=0; LED model holds 0xA5C3.
- Switch read: cpu_rd=1, addr=0xFFFFFC70, io_dW=0x1234, ACC_CYCLES=3 -> io_isCS_sw high exactly 3 cycles, io_isW=0; ready with rdata=0x00001234.
- Faults: addr=0xFFFFFC40 read -> ready+err, no CS, rdata=0. addr=0xFFFFFC61 write -> ready+err, no CS. rd&wr together -> ready+err.
- Back-to-back: hold cpu_wr for 2 accesses to 0xFFFFFC00, then one outside the window (0x00001000) -> two ready pulses each followed by a DONE gap; third request gets no CS and no ready.
- Reset mid-access: ACC_CYCLES=4, isReset at 2nd ACCESS cycle -> CS low next edge, no ready; LED data unchanged.
